multicycle_control: RTL and testbench

Main control sequencer for the multi-cycle MIPS core. It steps each instruction through fetch, decode, execute, memory and write-back, and drives every datapath mux and enable. Its `alu_op` output is the 2-bit code the downstream ALU control decoder turns into the 4-bit ALU operation. Memory accesses use a ready handshake, and the block keeps a retired-instruction counter and a sticky illegal-opcode flag.

---
 rtl/mips_pkg.sv | 69 ++++++
 rtl/mc_ctrl_decode.sv | 78 +++++++
 rtl/multicycle_control.sv | 121 ++++++++++++
 tb/tb_multicycle_control.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, the
// sequencer state enum, ALU/mux encodings and the packed control word.
package mips_pkg;

  localparam int unsigned OPCODE_W = 6;

  // Supported primary opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  // alu_op codes consumed by the ALU control decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU input B select
  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EXEC = 4'd11,
    ST_ADDI_WB   = 4'd12
  } state_t;

  // Full datapath control word
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_en;
  } ctrl_t;

  // True for every opcode the sequencer knows how to execute
  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode for the multi-cycle sequencer.
// Ports: state (current sequencer state), mem_ready, zero -> ctrl word.
// mem_ready and zero are the only inputs that bypass the state register.
module mc_ctrl_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        // IR load and PC+4 commit only when the fetch completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      ST_DECODE: begin
        // Branch target precomputed into ALUOut
        ctrl.alu_src_b = SRC_B_IMMSH;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_SUB;
        ctrl.pc_source = PC_SRC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      ST_JUMP: begin
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control sequencer of the multi-cycle MIPS core.
// Ports: clk, rst_n (async, active-low); opcode, zero, mem_ready inputs;
// datapath mux/enable outputs (combinational from state, plus mem_ready/zero);
// illegal_op (sticky) and retired (wrapping RET_W-bit instruction count).
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned RET_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                pc_en,
  output logic                illegal_op,
  output logic [RET_W-1:0]    retired
);

  state_t              state;
  state_t              state_next;
  logic [OPCODE_W-1:0] op_q;
  logic                retire_c;
  logic                illegal_c;
  ctrl_t               ctrl;

  // Control word decode
  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign pc_en      = ctrl.pc_en;

  // Next-state logic
  always_comb begin
    state_next = state;
    illegal_c  = 1'b0;
    unique case (state)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: if (mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        if      (opcode == OP_RTYPE)                     state_next = ST_R_EXEC;
        else if ((opcode == OP_LW) || (opcode == OP_SW)) state_next = ST_MEM_ADDR;
        else if (opcode == OP_BEQ)                       state_next = ST_BRANCH;
        else if (opcode == OP_J)                         state_next = ST_JUMP;
        else if (opcode == OP_ADDI)                      state_next = ST_ADDI_EXEC;
        else                                             state_next = ST_FETCH;
        illegal_c = !is_legal_op(opcode);
      end
      // Opcode bus may have moved on; use the copy latched in DECODE
      ST_MEM_ADDR:  state_next = (op_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) state_next = ST_MEM_WB;
      ST_MEM_WB:    state_next = ST_FETCH;
      ST_MEM_WRITE: if (mem_ready) state_next = ST_FETCH;
      ST_R_EXEC:    state_next = ST_R_WB;
      ST_R_WB:      state_next = ST_FETCH;
      ST_BRANCH:    state_next = ST_FETCH;
      ST_JUMP:      state_next = ST_FETCH;
      ST_ADDI_EXEC: state_next = ST_ADDI_WB;
      ST_ADDI_WB:   state_next = ST_FETCH;
      default:      state_next = ST_IDLE;
    endcase
  end

  // An instruction retires on its final-state exit to FETCH; illegal
  // returns leave from DECODE and are therefore excluded.
  assign retire_c = (state_next == ST_FETCH) &&
                    ((state == ST_MEM_WB) || (state == ST_MEM_WRITE) ||
                     (state == ST_R_WB)   || (state == ST_BRANCH)    ||
                     (state == ST_JUMP)   || (state == ST_ADDI_WB));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Opcode latch for the load/store split
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op_q <= '0;
    else if (state == ST_DECODE) op_q <= opcode;
  end

  // Retired-instruction counter, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retired <= '0;
    else if (retire_c) retired <= retired + RET_W'(1);
  end

  // Sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         illegal_op <= 1'b0;
    else if (illegal_c) illegal_op <= 1'b1;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (RET_W = 4 so the wrap is reachable).
module tb_multicycle_control;

  localparam int unsigned RET_W = 4;

  typedef enum int {
    B_IDLE, B_FETCH, B_DECODE, B_MEM_ADDR, B_MEM_READ, B_MEM_WB, B_MEM_WRITE,
    B_R_EXEC, B_R_WB, B_BRANCH, B_JUMP, B_ADDI_EXEC, B_ADDI_WB
  } bst_t;

  typedef struct {
    logic [14:0]      ctl;
    logic [RET_W-1:0] ret;
    logic             ill;
    int               idx;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = 6'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg;
  logic             reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [RET_W-1:0] retired;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_step  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.RET_W(RET_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .retired    (retired)
  );

  // Expected control word for a state, written from the state table
  function automatic logic [14:0] exp_ctl(bst_t s, logic r, logic z);
    logic mr, mw, io, irw, rd, m2r, rw, sa, pe;
    logic [1:0] sb, ao, ps;
    {mr, mw, io, irw, rd, m2r, rw, sa, pe} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      B_FETCH:     begin mr = 1; sb = 2'b01; irw = r; pe = r; end
      B_DECODE:    sb = 2'b11;
      B_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
      B_MEM_READ:  begin mr = 1; io = 1; end
      B_MEM_WB:    begin rw = 1; m2r = 1; end
      B_MEM_WRITE: begin mw = 1; io = 1; end
      B_R_EXEC:    begin sa = 1; ao = 2'b10; end
      B_R_WB:      begin rd = 1; rw = 1; end
      B_BRANCH:    begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      B_JUMP:      begin ps = 2'b10; pe = 1; end
      B_ADDI_EXEC: begin sa = 1; sb = 2'b10; end
      B_ADDI_WB:   rw = 1;
      default: ;
    endcase
    return {mr, mw, io, irw, rd, m2r, rw, sa, sb, ao, ps, pe};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show in it
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic z, input bst_t st, input int ret, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst;
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    e.ctl = exp_ctl(st, rdy, z);
    e.ret = RET_W'(ret);
    e.ill = ill;
    e.idx = n_step;
    n_step++;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e = exp_q.pop_front();
      act = {mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_source, pc_en};
      n_total++;
      if (act !== e.ctl) begin
        n_bad++;
        $display("FAIL ctl step=%0d got=%b want=%b", e.idx, act, e.ctl);
      end
      n_total++;
      if (retired !== e.ret) begin
        n_bad++;
        $display("FAIL retired step=%0d got=%0d want=%0d", e.idx, retired, e.ret);
      end
      n_total++;
      if (illegal_op !== e.ill) begin
        n_bad++;
        $display("FAIL illegal_op step=%0d got=%b want=%b", e.idx, illegal_op, e.ill);
      end
    end
  end

  initial begin
    // Reset, then release: IDLE for the release cycle
    step(0, 6'd0, 1, 0, B_IDLE, 0, 0);
    step(1, 6'd0, 1, 0, B_IDLE, 0, 0);
    // R-type
    step(1, 6'b000000, 1, 0, B_FETCH,  0, 0);
    step(1, 6'b000000, 1, 0, B_DECODE, 0, 0);
    step(1, 6'b111111, 1, 0, B_R_EXEC, 0, 0);
    step(1, 6'b111111, 1, 0, B_R_WB,   0, 0);
    // LW with three wait cycles in MEM_READ (8 cycles total)
    step(1, 6'b000000, 1, 0, B_FETCH,    1, 0);
    step(1, 6'b100011, 1, 0, B_DECODE,   1, 0);
    step(1, 6'b000000, 1, 0, B_MEM_ADDR, 1, 0);
    step(1, 6'b000000, 0, 0, B_MEM_READ, 1, 0);
    step(1, 6'b000000, 0, 0, B_MEM_READ, 1, 0);
    step(1, 6'b000000, 0, 0, B_MEM_READ, 1, 0);
    step(1, 6'b000000, 1, 0, B_MEM_READ, 1, 0);
    step(1, 6'b000000, 1, 0, B_MEM_WB,   1, 0);
    // BEQ taken, then not taken
    step(1, 6'b000000, 1, 0, B_FETCH,  2, 0);
    step(1, 6'b000100, 1, 0, B_DECODE, 2, 0);
    step(1, 6'b000000, 1, 1, B_BRANCH, 2, 0);
    step(1, 6'b000000, 1, 1, B_FETCH,  3, 0);
    step(1, 6'b000100, 1, 1, B_DECODE, 3, 0);
    step(1, 6'b000000, 1, 0, B_BRANCH, 3, 0);
    // Illegal opcode: back to FETCH, flag sticks, no retire
    step(1, 6'b000000, 1, 0, B_FETCH,  4, 0);
    step(1, 6'b111111, 1, 0, B_DECODE, 4, 0);
    // FETCH with one wait cycle
    step(1, 6'b000000, 0, 0, B_FETCH,  4, 1);
    step(1, 6'b000000, 1, 0, B_FETCH,  4, 1);
    // SW; opcode bus changed to LW after DECODE must not matter
    step(1, 6'b101011, 1, 0, B_DECODE,    4, 1);
    step(1, 6'b100011, 1, 0, B_MEM_ADDR,  4, 1);
    step(1, 6'b100011, 0, 0, B_MEM_WRITE, 4, 1);
    // Reset mid-MEM_WRITE: outputs drop within the cycle, counters clear
    step(0, 6'b100011, 1, 0, B_IDLE, 0, 0);
    step(0, 6'b000000, 1, 0, B_IDLE, 0, 0);
    step(1, 6'b000000, 1, 0, B_IDLE, 0, 0);
    // Sixteen jumps wrap the 4-bit counter 15 -> 0
    for (int k = 0; k < 16; k++) begin
      step(1, 6'b000000, 1, 0, B_FETCH,  k, 0);
      step(1, 6'b000010, 1, 0, B_DECODE, k, 0);
      step(1, 6'b000000, 1, 0, B_JUMP,   k, 0);
    end
    step(1, 6'b000000, 1, 0, B_FETCH, 0, 0);
    // ADDI
    step(1, 6'b001000, 1, 0, B_DECODE,    0, 0);
    step(1, 6'b000000, 1, 0, B_ADDI_EXEC, 0, 0);
    step(1, 6'b000000, 1, 0, B_ADDI_WB,   0, 0);
    step(1, 6'b000000, 1, 0, B_FETCH,     1, 0);
    @(posedge clk);
    @(posedge clk);
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
